change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Payout side of the vending machine. The coin counters accept money; this block returns the change.
- On a start strobe it latches a change amount in cents and pays it out one coin at a time using a greedy algorithm across six hoppers (100c, 50c, 25c, 10c, 5c, 1c).
- Each coin is driven by a solenoid pulse and confirmed by the hopper's drop sensor.
- Sits between the transaction logic (which computes change) and the coin hopper drivers.

Parameters:
- AW, 11, width of amount/remaining in cents (max 2047).
- PULSE_W, 4, cycles a drop line is held high per coin.
- ACK_TIMEOUT, 64, cycles from first drop cycle to wait for coin_ack before declaring a jam.
- GAP_W, 2, idle cycles between consecutive coins.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- amount  in  AW  change to pay, in cents; sampled with start.
- empty  in  6  per-hopper empty flag; idx 0=100c, 1=50c, 2=25c, 3=10c, 4=5c, 5=1c.
- coin_ack  in  1  hopper sensor pulse confirming one coin dropped.
- drop  out  6  one-hot solenoid drive, same indexing as empty.
- busy  out  1  high from the cycle after start is accepted until DONE/FAULT is resolved.
- done  out  1  one-cycle pulse on successful completion.
- fault  out  1  level; set on jam or unpayable remainder, held until next accepted start or rst.
- remaining  out  AW  cents still owed; live during payout.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: drop=0, busy=0, done=0, fault=0, remaining=0, state=IDLE.
- States: IDLE, SELECT, DROP, WAIT_ACK, GAP, FIN, FAULT.
- IDLE:
  - start=1 at edge T latches remaining<=amount, clears fault and sets busy; state goes to SELECT.
  - start while busy=1 is ignored.
- SELECT (one cycle):
  - If remaining==0, go to FIN.
  - Otherwise pick the lowest index k with value[k]<=remaining and empty[k]==0, register sel=k, and go to DROP.
  - If no such k exists, go to FAULT.
- DROP: drop[sel]=1 for exactly PULSE_W cycles, first drop cycle at T+2 for the first coin. Then go to WAIT_ACK.
- WAIT_ACK: drop=0. Wait for coin_ack.
- coin_ack rules:
  - coin_ack is honoured in DROP or WAIT_ACK.
  - On the ack cycle, remaining<=remaining-value[sel]; the state still completes DROP's PULSE_W cycles and then goes to GAP.
  - A second ack for the same coin is ignored.
  - coin_ack in any other state is ignored.
- Timeout: if no ack arrives within ACK_TIMEOUT cycles counted from the first drop cycle, go to FAULT with remaining unchanged.
- GAP: GAP_W cycles with drop=0, then back to SELECT.
- FIN: done=1 for one cycle, busy<=0, state goes to IDLE.
- FAULT: fault<=1, busy<=0, drop=0, state goes to IDLE. remaining holds the unpaid cents.
- An empty flag changing mid-coin does not abort the current coin; it only affects the next SELECT.
- At most one drop bit is ever high. drop is never high outside DROP.
- Subtraction never underflows because of the value<=remaining check at SELECT.
- Reset mid-operation: the next edge forces all outputs to their reset values; a coin in flight is not accounted for.
- Denomination values: 100, 50, 25, 10, 5, 1.

Test Plan:
- Basic payout: amount=185, empty=0, ack 3 cycles after each drop rise.
  - Drop order: drop[0], drop[1], drop[2], drop[3].
  - Each pulse is PULSE_W=4 cycles with a GAP_W=2 gap between coins.
  - remaining steps 185→85→35→10→0; done pulses once, then busy=0.
- Zero amount: amount=0.
  - drop stays 0; done=1 exactly at T+2; fault=0.
- Empty hopper fallback: amount=75, empty[2]=1.
  - Drops in order: 50c, 10c, 10c, 5c (indices 1,3,3,4).
  - remaining ends at 0 and done pulses.
- Unpayable remainder: amount=3, empty[5]=1.
  - No drop; fault=1, remaining=3, busy=0, no done.
  - A following start with amount=0 clears fault and pulses done.
- Jam: amount=100, coin_ack never asserted.
  - drop[0] high for 4 cycles.
  - fault rises once the 64-cycle timeout window expires; remaining=100.
  - A stray coin_ack afterwards is ignored.
- Protocol and reset edge cases:
  - start pulsed during payout of amount=50: ignored, and the payout finishes with exactly one drop[1].
  - rst asserted during DROP: at the next edge drop=0, busy=0, remaining=0, fault=0.

Source files
------------

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Payout side of the vending machine. A start strobe latches a change amount
// in cents. The block then pays it out one coin at a time, greedily, from six
// hoppers (100c, 50c, 25c, 10c, 5c, 1c). Each coin is a solenoid pulse on
// drop[k] that the hopper's drop sensor confirms with coin_ack. A coin that is
// never confirmed, or a remainder that no non-empty hopper can pay, ends the
// payout with the fault level set.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle payout request, accepted only while busy=0
//   amount     in   change to pay in cents, sampled with start
//   empty      in   per-hopper empty flags (0=100c .. 5=1c)
//   coin_ack   in   hopper sensor pulse confirming one dropped coin
//   drop       out  one-hot solenoid drive, same indexing as empty
//   busy       out  payout in progress
//   done       out  one-cycle pulse on successful completion
//   fault      out  jam or unpayable remainder; held until next start or rst
//   remaining  out  cents still owed
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AW          = 11,
    parameter int PULSE_W     = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_W       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amount,
    input  logic [5:0]    empty,
    input  logic          coin_ack,
    output logic [5:0]    drop,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [AW-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_DROP,
        S_WAIT_ACK,
        S_GAP,
        S_FIN,
        S_FAULT
    } state_t;

    // One counter serves the pulse, the ack window and the gap; it must reach
    // ACK_TIMEOUT-1 without wrapping.
    localparam int CW = $clog2(ACK_TIMEOUT + PULSE_W + GAP_W + 1);

    function automatic logic [AW-1:0] coin_value(input logic [2:0] idx);
        case (idx)
            3'd0:    coin_value = AW'(100);
            3'd1:    coin_value = AW'(50);
            3'd2:    coin_value = AW'(25);
            3'd3:    coin_value = AW'(10);
            3'd4:    coin_value = AW'(5);
            3'd5:    coin_value = AW'(1);
            default: coin_value = '0;
        endcase
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_sel;
    logic          r_acked;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_fault;
    logic [AW-1:0] r_remaining;

    logic [2:0]    w_pick;
    logic          w_found;
    logic          w_ack_now;
    logic          w_pulse_end;
    logic          w_gap_end;
    logic          w_timeout;

    // Greedy choice: scanning from the small coins upward so the last hit,
    // i.e. the largest payable non-empty denomination, wins.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (!empty[k] && (coin_value(3'(k)) <= r_remaining)) begin
                w_found = 1'b1;
                w_pick  = 3'(k);
            end
        end
    end

    // Only the first ack of a coin counts, and only while the coin is live.
    assign w_ack_now   = coin_ack && !r_acked &&
                         ((r_state == S_DROP) || (r_state == S_WAIT_ACK));
    assign w_pulse_end = (r_cnt == CW'(PULSE_W - 1));
    assign w_gap_end   = (r_cnt == CW'(GAP_W - 1));
    assign w_timeout   = (r_cnt == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        drop   = 6'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SELECT;
            end
            S_SELECT: begin
                if (r_remaining == '0) w_next = S_FIN;
                else if (w_found)      w_next = S_DROP;
                else                   w_next = S_FAULT;
            end
            S_DROP: begin
                drop = 6'(1) << r_sel;
                if (w_pulse_end) w_next = (r_acked || w_ack_now) ? S_GAP : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_ack_now)      w_next = S_GAP;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_GAP: begin
                if (w_gap_end) w_next = S_SELECT;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The counter restarts on every state change except DROP -> WAIT_ACK, so
    // the ack window keeps counting from the first drop cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) ||
                     ((w_next != r_state) &&
                      !((r_state == S_DROP) && (w_next == S_WAIT_ACK)))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 3'd0;
            r_acked     <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= amount;
                        r_fault     <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SELECT: begin
                    r_sel   <= w_pick;
                    r_acked <= 1'b0;
                end
                S_DROP, S_WAIT_ACK: begin
                    // Cannot underflow: SELECT only picks coins <= remaining.
                    if (w_ack_now) begin
                        r_remaining <= r_remaining - coin_value(r_sel);
                        r_acked     <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_busy <= 1'b0;
                end
                S_FAULT: begin
                    r_busy  <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign fault     = r_fault;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Drives payout transactions and acts as the hopper: it acks each coin a
// chosen number of cycles after the drop line rises (or never, for a jam).
// Expected coin sequences and amounts come from a plain greedy model of the
// payout rules; expected timing comes from the pulse/gap/timeout rules.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int AW          = 11;
    localparam int PULSE_W     = 4;
    localparam int ACK_TIMEOUT = 64;
    localparam int GAP_W       = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] amount;
    logic [5:0]    empty;
    logic          coin_ack;
    logic [5:0]    drop;
    logic          busy;
    logic          done;
    logic          fault;
    logic [AW-1:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model results
    int exp_idx[$];
    int exp_rem[$];
    int exp_final;
    bit exp_fault;
    bit exp_jam;

    always #5 clk = ~clk;

    change_dispenser #(
        .AW(AW), .PULSE_W(PULSE_W), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .empty(empty),
        .coin_ack(coin_ack), .drop(drop), .busy(busy), .done(done),
        .fault(fault), .remaining(remaining)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int denom(input int k);
        case (k)
            0: return 100;
            1: return 50;
            2: return 25;
            3: return 10;
            4: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Greedy payout with a fixed empty mask; coin number jam_coin never gets
    // confirmed, which stops the payout with that coin still owed.
    function automatic void model(input int amt, input logic [5:0] emp, input int jam_coin);
        int  rem;
        int  k;
        bit  fin;
        rem = amt;
        fin = 1'b0;
        exp_idx.delete();
        exp_rem.delete();
        exp_fault = 1'b0;
        exp_jam   = 1'b0;
        while (!fin) begin
            k = -1;
            if (rem == 0) begin
                fin = 1'b1;
            end else begin
                for (int j = 0; j < 6; j++)
                    if (k < 0 && !emp[j] && denom(j) <= rem) k = j;
                if (k < 0) begin
                    exp_fault = 1'b1;
                    fin       = 1'b1;
                end else begin
                    exp_idx.push_back(k);
                    exp_rem.push_back(rem);
                    if (exp_idx.size() - 1 == jam_coin) begin
                        exp_fault = 1'b1;
                        exp_jam   = 1'b1;
                        fin       = 1'b1;
                    end else begin
                        rem -= denom(k);
                    end
                end
            end
        end
        exp_final = rem;
    endfunction

    // fixed_delay < 0 picks a random ack delay per coin; dbl sends a second
    // ack one cycle after the first; extra_start_c > 0 pulses start then.
    task automatic run_txn(input string name, input int amt, input logic [5:0] emp,
                           input int fixed_delay, input int jam_coin, input bit dbl,
                           input int extra_start_c);
        int c, ack_at, ack2_at, cur_w, done_cnt, done_c, fault_c, end_c;
        int bad_hot, sel_c, exp_end, n, d, r;
        logic [5:0] prev_drop;
        int o_idx[$], o_rise[$], o_w[$], o_rem[$], o_del[$];

        model(amt, emp, jam_coin);
        @(negedge clk);
        amount   = AW'(amt);
        empty    = emp;
        start    = 1'b1;
        coin_ack = 1'b0;
        c = 0; ack_at = -100; ack2_at = -100; cur_w = 0; prev_drop = 6'b0;
        done_cnt = 0; done_c = -1; fault_c = -1; end_c = -1; bad_hot = 0;

        while (end_c < 0 && c < 20000) begin
            @(negedge clk);
            c++;
            start  = (c == extra_start_c);
            amount = AW'($urandom_range(0, 2047));
            if (c == 1) begin
                check({name, ":busy_after_start"}, busy, 1);
                check({name, ":remaining_latched"}, remaining, amt);
                check({name, ":fault_cleared"}, fault, 0);
            end
            if (drop != 6'b0) begin
                if (!$onehot(drop)) bad_hot++;
                if (prev_drop == 6'b0) begin
                    if (o_idx.size() == jam_coin)  d = ACK_TIMEOUT;
                    else if (fixed_delay >= 0)     d = fixed_delay;
                    else                           d = $urandom_range(0, 9);
                    o_idx.push_back($clog2(drop));
                    o_rise.push_back(c);
                    o_rem.push_back(int'(remaining));
                    o_del.push_back(d);
                    ack_at  = c + d;
                    ack2_at = dbl ? c + d + 1 : -100;
                    cur_w   = 1;
                end else begin
                    cur_w++;
                    if (drop != prev_drop) bad_hot++;
                end
            end else if (prev_drop != 6'b0) begin
                o_w.push_back(cur_w);
            end
            prev_drop = drop;
            coin_ack  = (c == ack_at) || (c == ack2_at);
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (fault && fault_c < 0) fault_c = c;
            if (!busy) end_c = c;
        end
        start    = 1'b0;
        coin_ack = 1'b0;

        check({name, ":terminated"}, int'(end_c >= 0), 1);
        check({name, ":coin_count"}, o_idx.size(), exp_idx.size());
        check({name, ":pulse_count"}, o_w.size(), o_idx.size());
        check({name, ":onehot"}, bad_hot, 0);
        n = (o_idx.size() < exp_idx.size()) ? o_idx.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:coin%0d_idx", name, i), o_idx[i], exp_idx[i]);
            check($sformatf("%s:coin%0d_rem", name, i), o_rem[i], exp_rem[i]);
        end
        foreach (o_w[i]) check($sformatf("%s:coin%0d_width", name, i), o_w[i], PULSE_W);
        if (o_rise.size() > 0) check({name, ":first_drop_cycle"}, o_rise[0], 2);
        for (int i = 1; i < o_rise.size(); i++)
            check($sformatf("%s:coin%0d_rise", name, i), o_rise[i],
                  max2(PULSE_W - 1, o_del[i-1]) + o_rise[i-1] + GAP_W + 2);

        // Cycle of the SELECT that ends the payout, then the expected end.
        if (o_rise.size() == 0) begin
            sel_c = 1;
            r     = 0;
        end else begin
            r     = o_rise[o_rise.size()-1];
            sel_c = r + max2(PULSE_W - 1, o_del[o_del.size()-1]) + GAP_W + 1;
        end
        exp_end = exp_jam ? r + ACK_TIMEOUT + 1 : sel_c + 2;
        check({name, ":end_cycle"}, end_c, exp_end);
        check({name, ":done_count"}, done_cnt, exp_fault ? 0 : 1);
        if (!exp_fault) check({name, ":done_cycle"}, done_c, sel_c + 1);
        check({name, ":fault_cycle"}, fault_c, exp_fault ? exp_end : -1);
        check({name, ":final_remaining"}, remaining, exp_final);
        check({name, ":drop_idle"}, drop, 0);
    endtask

    initial begin
        logic [5:0] emp;
        int         jam;
        rst      = 1'b1;
        start    = 1'b0;
        amount   = '0;
        empty    = 6'b0;
        coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset:drop", drop, 0);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:fault", fault, 0);
        check("reset:remaining", remaining, 0);
        rst = 1'b0;

        run_txn("basic185", 185, 6'b000000, 3, -1, 1'b0, 0);
        run_txn("zero", 0, 6'b000000, 3, -1, 1'b0, 0);
        run_txn("empty25", 75, 6'b000100, -1, -1, 1'b0, 0);

        run_txn("unpayable", 3, 6'b100000, 3, -1, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("unpayable:fault_held", fault, 1);
        check("unpayable:remaining_held", remaining, 3);
        run_txn("after_fault", 0, 6'b000000, 3, -1, 1'b0, 0);

        run_txn("jam", 100, 6'b000000, 3, 0, 1'b0, 0);
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        @(negedge clk);
        check("jam:stray_ack_remaining", remaining, 100);
        check("jam:stray_ack_fault", fault, 1);
        check("jam:stray_ack_busy", busy, 0);

        run_txn("late_ack63", 100, 6'b000000, ACK_TIMEOUT - 1, -1, 1'b0, 0);
        run_txn("start_while_busy", 50, 6'b000000, 3, -1, 1'b0, 4);
        run_txn("double_ack", 65, 6'b000000, 0, -1, 1'b1, 0);

        // Reset in the middle of a coin pulse.
        @(negedge clk);
        amount = AW'(100);
        empty  = 6'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && drop == 6'b0; i++) @(negedge clk);
        check("rst_mid:drop_active", int'(drop != 6'b0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid:drop", drop, 0);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:remaining", remaining, 0);
        check("rst_mid:fault", fault, 0);
        check("rst_mid:done", done, 0);
        rst = 1'b0;

        for (int t = 0; t < 25; t++) begin
            emp = 6'b0;
            for (int b = 0; b < 6; b++) emp[b] = ($urandom_range(0, 4) == 0);
            jam = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_txn($sformatf("rand%0d", t), int'($urandom_range(0, 250)), emp, -1, jam,
                    1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
